// File: rtl/rob_queue.sv
// Reorder buffer: in-order allocate, out-of-order completion, in-order retire from head.
// Raises a precise exception when the head entry completes faulting, then self-clears.
module rob_queue #(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned ALLOC_W  = 2,
   parameter int unsigned WB_PORTS = 4,
   parameter int unsigned RETIRE_W = 2,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned DST_W    = 5,
   localparam int unsigned ROB_AW  = $clog2(DEPTH),
   localparam int unsigned PTR_W   = ROB_AW + 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic [ALLOC_W-1:0]           alloc_valid,
   input  logic [ALLOC_W*DST_W-1:0]     alloc_dst,
   input  logic [ALLOC_W*32-1:0]        alloc_pcplus8,
   output logic                         alloc_ready,
   output logic [ALLOC_W*ROB_AW-1:0]    alloc_idx,
   input  logic [WB_PORTS-1:0]          wb_valid,
   input  logic [WB_PORTS*ROB_AW-1:0]   wb_idx,
   input  logic [WB_PORTS*DATA_W-1:0]   wb_data,
   input  logic [WB_PORTS-1:0]          wb_exc,
   input  logic [WB_PORTS*5-1:0]        wb_exc_code,
   output logic [RETIRE_W-1:0]          retire_valid,
   output logic [RETIRE_W*DST_W-1:0]    retire_dst,
   output logic [RETIRE_W*DATA_W-1:0]   retire_data,
   output logic                         exc_valid,
   output logic [4:0]                   exc_code,
   output logic [31:0]                  exc_pc,
   output logic [PTR_W-1:0]             count
);

   localparam int unsigned CODE_W = 5;
   localparam int unsigned PC_W   = 32;

   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  done;
   logic [DEPTH-1:0]  exc;
   logic [CODE_W-1:0] code_q [DEPTH];
   logic [DST_W-1:0]  dst_q  [DEPTH];
   logic [PC_W-1:0]   pc_q   [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];

   logic [ROB_AW-1:0]   head_idx;
   logic [ROB_AW-1:0]   tail_idx;
   logic [PTR_W-1:0]    free_cnt;
   logic [PTR_W-1:0]    alloc_n;
   logic [PTR_W-1:0]    retire_n;
   logic [RETIRE_W-1:0] retire_ok;
   logic                alloc_fire;
   logic                exc_head;
   logic                clear;

   assign head_idx = head[ROB_AW-1:0];
   assign tail_idx = tail[ROB_AW-1:0];

   // Occupancy; the wrap bit keeps full (DEPTH) and empty (0) distinct
   assign count       = tail - head;
   assign free_cnt    = PTR_W'(DEPTH) - count;
   assign alloc_ready = (free_cnt >= PTR_W'(ALLOC_W));
   assign alloc_fire  = alloc_ready & (|alloc_valid);

   always_comb begin
      alloc_idx = '0;
      alloc_n   = '0;
      for (int unsigned i = 0; i < ALLOC_W; i++) begin
         alloc_idx[i*ROB_AW +: ROB_AW] = tail_idx + ROB_AW'(i);
         alloc_n = alloc_n + PTR_W'(alloc_valid[i]);
      end
   end

   // Faulting head entry: report it and clear the whole buffer on this edge
   assign exc_head  = busy[head_idx] & done[head_idx] & exc[head_idx];
   assign exc_valid = exc_head & ~flush;
   assign exc_code  = code_q[head_idx];
   assign exc_pc    = pc_q[head_idx] - 32'd8;
   assign clear     = reset | flush | exc_head;

   // Retire lane k only if every entry from head through head+k is cleanly complete
   always_comb begin
      logic              chain;
      logic [ROB_AW-1:0] ridx;
      chain       = 1'b1;
      retire_ok   = '0;
      retire_n    = '0;
      retire_dst  = '0;
      retire_data = '0;
      for (int unsigned k = 0; k < RETIRE_W; k++) begin
         ridx  = head_idx + ROB_AW'(k);
         chain = chain & busy[ridx] & done[ridx] & ~exc[ridx];
         retire_ok[k] = chain;
         retire_n     = retire_n + PTR_W'(chain);
         retire_dst[k*DST_W +: DST_W]    = dst_q[ridx];
         retire_data[k*DATA_W +: DATA_W] = data_q[ridx];
      end
   end

   assign retire_valid = flush ? '0 : retire_ok;

   // Control state: pointers and per-entry status bits
   always_ff @(posedge clk) begin
      if (clear) begin
         head <= '0;
         tail <= '0;
         busy <= '0;
         done <= '0;
         exc  <= '0;
      end else begin
         // Ascending port order lets the highest port win on a shared index
         for (int unsigned p = 0; p < WB_PORTS; p++) begin
            if (wb_valid[p] && busy[wb_idx[p*ROB_AW +: ROB_AW]]) begin
               done[wb_idx[p*ROB_AW +: ROB_AW]] <= 1'b1;
               exc[wb_idx[p*ROB_AW +: ROB_AW]]  <= wb_exc[p];
            end
         end
         for (int unsigned k = 0; k < RETIRE_W; k++) begin
            if (retire_ok[k]) begin
               busy[head_idx + ROB_AW'(k)] <= 1'b0;
               done[head_idx + ROB_AW'(k)] <= 1'b0;
            end
         end
         if (alloc_fire) begin
            for (int unsigned i = 0; i < ALLOC_W; i++) begin
               if (alloc_valid[i]) begin
                  busy[tail_idx + ROB_AW'(i)] <= 1'b1;
                  done[tail_idx + ROB_AW'(i)] <= 1'b0;
                  exc[tail_idx + ROB_AW'(i)]  <= 1'b0;
               end
            end
            tail <= tail + alloc_n;
         end
         head <= head + retire_n;
      end
   end

   // Payload storage; only meaningful while the entry is busy, so no reset needed
   always_ff @(posedge clk) begin
      for (int unsigned p = 0; p < WB_PORTS; p++) begin
         if (wb_valid[p] && busy[wb_idx[p*ROB_AW +: ROB_AW]]) begin
            data_q[wb_idx[p*ROB_AW +: ROB_AW]] <= wb_data[p*DATA_W +: DATA_W];
            code_q[wb_idx[p*ROB_AW +: ROB_AW]] <= wb_exc_code[p*CODE_W +: CODE_W];
         end
      end
      if (alloc_fire) begin
         for (int unsigned i = 0; i < ALLOC_W; i++) begin
            if (alloc_valid[i]) begin
               dst_q[tail_idx + ROB_AW'(i)] <= alloc_dst[i*DST_W +: DST_W];
               pc_q[tail_idx + ROB_AW'(i)]  <= alloc_pcplus8[i*PC_W +: PC_W];
            end
         end
      end
   end

endmodule

// File: tb/tb_rob_queue.sv
// Bench for rob_queue: directed scenarios plus random traffic against a queue-based model.
module tb_rob_queue;

   localparam int DEPTH    = 16;
   localparam int ALLOC_W  = 2;
   localparam int WB_PORTS = 4;
   localparam int RETIRE_W = 2;
   localparam int DATA_W   = 32;
   localparam int DST_W    = 5;
   localparam int AW       = 4;

   logic                       clk;
   logic                       reset;
   logic                       flush;
   logic [ALLOC_W-1:0]         alloc_valid;
   logic [ALLOC_W*DST_W-1:0]   alloc_dst;
   logic [ALLOC_W*32-1:0]      alloc_pcplus8;
   logic                       alloc_ready;
   logic [ALLOC_W*AW-1:0]      alloc_idx;
   logic [WB_PORTS-1:0]        wb_valid;
   logic [WB_PORTS*AW-1:0]     wb_idx;
   logic [WB_PORTS*DATA_W-1:0] wb_data;
   logic [WB_PORTS-1:0]        wb_exc;
   logic [WB_PORTS*5-1:0]      wb_exc_code;
   logic [RETIRE_W-1:0]        retire_valid;
   logic [RETIRE_W*DST_W-1:0]  retire_dst;
   logic [RETIRE_W*DATA_W-1:0] retire_data;
   logic                       exc_valid;
   logic [4:0]                 exc_code;
   logic [31:0]                exc_pc;
   logic [AW:0]                count;

   rob_queue #(
      .DEPTH(DEPTH), .ALLOC_W(ALLOC_W), .WB_PORTS(WB_PORTS),
      .RETIRE_W(RETIRE_W), .DATA_W(DATA_W), .DST_W(DST_W)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .alloc_valid(alloc_valid), .alloc_dst(alloc_dst), .alloc_pcplus8(alloc_pcplus8),
      .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
      .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
      .wb_exc(wb_exc), .wb_exc_code(wb_exc_code),
      .retire_valid(retire_valid), .retire_dst(retire_dst), .retire_data(retire_data),
      .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: program-order queue of live entries, front = oldest
   typedef struct {
      logic [4:0]  dst;
      logic [31:0] pc;
      bit          done;
      bit          exc;
      logic [4:0]  code;
      logic [31:0] data;
   } ent_t;

   ent_t q[$];
   int   head_m;
   int   n_checks;
   int   n_errors;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      reset = 1'b0;
      flush = 1'b0;
      alloc_valid = '0;
      alloc_dst = '0;
      alloc_pcplus8 = '0;
      wb_valid = '0;
      wb_idx = '0;
      wb_data = '0;
      wb_exc = '0;
      wb_exc_code = '0;
   endtask

   task automatic drv_alloc(input int n, input logic [4:0] dst0, input logic [31:0] pc0);
      for (int i = 0; i < ALLOC_W; i++) begin
         alloc_valid[i] = (i < n);
         alloc_dst[i*DST_W +: DST_W] = dst0 + 5'(i);
         alloc_pcplus8[i*32 +: 32] = pc0 + 32'(4 * i);
      end
   endtask

   task automatic drv_wb(input int p, input int idx, input logic [31:0] d,
                         input bit e, input logic [4:0] c);
      wb_valid[p] = 1'b1;
      wb_idx[p*AW +: AW] = AW'(idx);
      wb_data[p*DATA_W +: DATA_W] = d;
      wb_exc[p] = e;
      wb_exc_code[p*5 +: 5] = c;
   endtask

   // Compare all outputs with the model, clock one edge, advance the model
   task automatic cycle();
      int n;
      int nret;
      bit exp_exc;
      bit chain;
      logic [RETIRE_W-1:0] exp_rv;
      ent_t e;
      #1;
      n = q.size();
      check("count", 64'(count), 64'(n));
      check("alloc_ready", 64'(alloc_ready), 64'(DEPTH - n >= ALLOC_W));
      for (int i = 0; i < ALLOC_W; i++)
         check("alloc_idx", 64'(alloc_idx[i*AW +: AW]), 64'((head_m + n + i) % DEPTH));
      exp_exc = (n > 0) && q[0].done && q[0].exc;
      chain = 1'b1;
      nret = 0;
      exp_rv = '0;
      for (int k = 0; k < RETIRE_W; k++) begin
         if (chain && k < n && q[k].done && !q[k].exc) begin
            exp_rv[k] = 1'b1;
            nret++;
         end else begin
            chain = 1'b0;
         end
      end
      if (flush) exp_rv = '0;
      check("retire_valid", 64'(retire_valid), 64'(exp_rv));
      for (int k = 0; k < RETIRE_W; k++) begin
         if (exp_rv[k]) begin
            check("retire_dst", 64'(retire_dst[k*DST_W +: DST_W]), 64'(q[k].dst));
            check("retire_data", 64'(retire_data[k*DATA_W +: DATA_W]), 64'(q[k].data));
         end
      end
      check("exc_valid", 64'(exc_valid), 64'(exp_exc && !flush));
      if (exp_exc && !flush) begin
         check("exc_code", 64'(exc_code), 64'(q[0].code));
         check("exc_pc", 64'(exc_pc), 64'(q[0].pc - 32'd8));
      end
      @(posedge clk);
      if (reset || flush || exp_exc) begin
         q.delete();
         head_m = 0;
      end else begin
         for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_valid[p]) begin
               int pos;
               pos = (int'(wb_idx[p*AW +: AW]) - head_m + DEPTH) % DEPTH;
               if (pos < n) begin
                  q[pos].done = 1'b1;
                  q[pos].exc  = wb_exc[p];
                  q[pos].code = wb_exc_code[p*5 +: 5];
                  q[pos].data = wb_data[p*DATA_W +: DATA_W];
               end
            end
         end
         for (int k = 0; k < nret; k++) void'(q.pop_front());
         head_m = (head_m + nret) % DEPTH;
         if (DEPTH - n >= ALLOC_W) begin
            for (int i = 0; i < ALLOC_W; i++) begin
               if (alloc_valid[i]) begin
                  e.dst = alloc_dst[i*DST_W +: DST_W];
                  e.pc = alloc_pcplus8[i*32 +: 32];
                  e.done = 1'b0;
                  e.exc = 1'b0;
                  e.code = '0;
                  e.data = '0;
                  q.push_back(e);
               end
            end
         end
      end
      @(negedge clk);
      clear_inputs();
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      q.delete();
      head_m = 0;
      #1;
      check("rst_count", 64'(count), 64'(0));
      check("rst_alloc_ready", 64'(alloc_ready), 64'(1));
      check("rst_retire_valid", 64'(retire_valid), 64'(0));
      check("rst_exc_valid", 64'(exc_valid), 64'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      head_m = 0;
      clear_inputs();

      // Fill: pairs 0/1 .. 14/15, then full and further alloc ignored
      do_reset();
      for (int c = 0; c < 8; c++) begin
         check("t1_idx0", 64'(alloc_idx[AW-1:0]), 64'(2 * c));
         check("t1_idx1", 64'(alloc_idx[2*AW-1:AW]), 64'(2 * c + 1));
         drv_alloc(2, 5'(2 * c + 1), 32'h1000 + 32'(8 * c));
         cycle();
      end
      check("t1_count_full", 64'(count), 64'(16));
      check("t1_ready_full", 64'(alloc_ready), 64'(0));
      drv_alloc(2, 5'd30, 32'h2000);
      cycle();
      check("t1_count_ignored", 64'(count), 64'(16));

      // Out-of-order completion: no retire until the head is done
      drv_wb(0, 1, 32'h101, 1'b0, 5'd0);
      cycle();
      check("t2_no_retire", 64'(retire_valid), 64'(0));
      drv_wb(0, 0, 32'h100, 1'b0, 5'd0);
      cycle();
      check("t2_rv", 64'(retire_valid), 64'(2'b11));
      check("t2_dst0", 64'(retire_dst[DST_W-1:0]), 64'(1));
      check("t2_dst1", 64'(retire_dst[2*DST_W-1:DST_W]), 64'(2));
      check("t2_data0", 64'(retire_data[DATA_W-1:0]), 64'(32'h100));
      check("t2_data1", 64'(retire_data[2*DATA_W-1:DATA_W]), 64'(32'h101));
      cycle();
      check("t2_count", 64'(count), 64'(14));

      // Tail wrap: alloc lands at 0/1 while 2/3 retire in the same cycle
      drv_wb(0, 2, 32'h102, 1'b0, 5'd0);
      drv_wb(1, 3, 32'h103, 1'b0, 5'd0);
      cycle();
      check("t3_idx0", 64'(alloc_idx[AW-1:0]), 64'(0));
      check("t3_idx1", 64'(alloc_idx[2*AW-1:AW]), 64'(1));
      check("t3_ready", 64'(alloc_ready), 64'(1));
      drv_alloc(2, 5'd20, 32'h3000);
      cycle();
      check("t3_count", 64'(count), 64'(14));
      drv_alloc(2, 5'd22, 32'h3010);
      cycle();
      check("t3_count_full", 64'(count), 64'(16));
      check("t3_ready_low", 64'(alloc_ready), 64'(0));

      // Precise exception at entry 2 after 0/1 retire
      do_reset();
      drv_alloc(2, 5'd1, 32'h8000_0008);
      cycle();
      drv_alloc(2, 5'd3, 32'hBFC0_0108);
      cycle();
      drv_wb(0, 0, 32'hA0, 1'b0, 5'd0);
      drv_wb(1, 1, 32'hA1, 1'b0, 5'd0);
      drv_wb(2, 2, 32'hA2, 1'b1, 5'h04);
      cycle();
      check("t4_rv", 64'(retire_valid), 64'(2'b11));
      check("t4_no_exc_yet", 64'(exc_valid), 64'(0));
      cycle();
      check("t4_exc_valid", 64'(exc_valid), 64'(1));
      check("t4_exc_pc", 64'(exc_pc), 64'(32'hBFC0_0100));
      check("t4_exc_code", 64'(exc_code), 64'(5'h04));
      check("t4_rv_low", 64'(retire_valid), 64'(0));
      drv_alloc(2, 5'd9, 32'h4000);
      cycle();
      check("t4_count", 64'(count), 64'(0));
      check("t4_idx0", 64'(alloc_idx[AW-1:0]), 64'(0));

      // External flush beats same-cycle alloc, wb and retire
      do_reset();
      drv_alloc(2, 5'd7, 32'h5000);
      cycle();
      drv_wb(0, 0, 32'hB0, 1'b0, 5'd0);
      drv_wb(1, 1, 32'hB1, 1'b0, 5'd0);
      cycle();
      check("t5_rv_before", 64'(retire_valid), 64'(2'b11));
      flush = 1'b1;
      drv_alloc(2, 5'd11, 32'h5100);
      drv_wb(2, 0, 32'hB2, 1'b0, 5'd0);
      #1;
      check("t5_rv_gated", 64'(retire_valid), 64'(0));
      cycle();
      check("t5_count", 64'(count), 64'(0));
      drv_wb(0, 0, 32'hC0, 1'b0, 5'd0);
      drv_wb(1, 1, 32'hC1, 1'b0, 5'd0);
      cycle();
      check("t5_stale_wb", 64'(count), 64'(0));
      drv_alloc(2, 5'd12, 32'h5200);
      cycle();
      cycle();
      check("t5_fresh_not_done", 64'(retire_valid), 64'(0));
      check("t5_count2", 64'(count), 64'(2));

      // Same index on two ports: highest port wins
      do_reset();
      for (int c = 0; c < 3; c++) begin
         drv_alloc(2, 5'(2 * c), 32'h6000 + 32'(8 * c));
         cycle();
      end
      for (int p = 0; p < 4; p++) drv_wb(p, p, 32'hD0 + 32'(p), 1'b0, 5'd0);
      cycle();
      check("t6_rv01", 64'(retire_valid), 64'(2'b11));
      drv_wb(0, 4, 32'h11, 1'b0, 5'd0);
      drv_wb(3, 4, 32'h33, 1'b0, 5'd0);
      drv_wb(1, 5, 32'h55, 1'b0, 5'd0);
      cycle();
      cycle();
      check("t6_rv45", 64'(retire_valid), 64'(2'b11));
      check("t6_data4", 64'(retire_data[DATA_W-1:0]), 64'(32'h33));
      check("t6_data5", 64'(retire_data[2*DATA_W-1:DATA_W]), 64'(32'h55));
      cycle();

      // Random traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         int n;
         n = q.size();
         if ($urandom_range(0, 63) == 0) flush = 1'b1;
         if ($urandom_range(0, 999) == 0) reset = 1'b1;
         drv_alloc(int'($urandom_range(0, ALLOC_W)), 5'($urandom), $urandom);
         for (int p = 0; p < WB_PORTS; p++) begin
            if ($urandom_range(0, 1) == 1) begin
               int idx;
               if (n > 0 && $urandom_range(0, 7) != 0)
                  idx = (head_m + int'($urandom_range(0, n - 1))) % DEPTH;
               else
                  idx = int'($urandom_range(0, DEPTH - 1));
               drv_wb(p, idx, $urandom, ($urandom_range(0, 39) == 0), 5'($urandom));
            end
         end
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
